uart_rx_fsm: RTL

//  Frame-level controller for the UART receiver. Detects the start edge, runs the

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_edge_bit_counter.sv | 36 +++
 rtl/uart_rx_fsm.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receiver frame controller
// Purpose: frame state encoding, parity type constants and the parity helper.
// Ports: none (package).
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit the transmitter should have sent, given the XOR of the payload.
    function automatic logic expected_parity(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - oversampling edge counter and frame bit counter
// Purpose: counts oversampling edges inside a bit and bits inside a frame.
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   enable      frame in progress (sampler enable); counters held at 0 when low
//   prescale    latched oversampling ratio
//   edge_count  edge index 0..prescale-1 within the current bit
//   bit_count   bit index within the frame (start bit = 0)
//   wrap        last edge of the current bit (the consume point)
module uart_rx_edge_bit_counter #(
    parameter int BIT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             enable,
    input  logic [5:0]       prescale,
    output logic [5:0]       edge_count,
    output logic [BIT_W-1:0] bit_count,
    output logic             wrap
);

    assign wrap = enable && (edge_count == (prescale - 6'd1));

    always_ff @(posedge CLK) begin
        if (RST || !enable) begin
            edge_count <= 6'd0;
            bit_count  <= '0;
        end else if (wrap) begin
            edge_count <= 6'd0;
            bit_count  <= bit_count + BIT_W'(1);
        end else begin
            edge_count <= edge_count + 6'd1;
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver frame controller (start/data/parity/stop)
// Purpose: detects the start edge, enables the sampler for the whole frame, shifts
//   payload bits in LSB first, checks start/parity/stop and reports the frame.
// Optional feature: define UART_RX_BREAK_DET_EN to enable break-frame detection;
//   otherwise break_det is tied low.
// Ports:
//   CLK, RST     oversampling clock, synchronous active-high reset
//   S_DATA       synchronised serial line, idle high
//   Prescale     oversampling ratio (8, 16, 32), latched at frame start
//   PAR_EN       frame carries a parity bit (latched)
//   PAR_TYP      0 even / 1 odd parity (latched)
//   sampled_bit  majority-vote result from the sampler
//   dat_samp_en  sampler enable, high for the whole frame
//   edge_count   oversampling edge index within the current bit
//   P_DATA       last good payload
//   data_valid   one-cycle pulse: good frame on P_DATA
//   par_err      one-cycle pulse: parity mismatch
//   stp_err      one-cycle pulse: stop bit sampled 0
//   break_det    one-cycle pulse: all-zero frame with stop bit 0
import uart_rx_pkg::*;

module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  S_DATA,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_count,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  break_det
);

    localparam int BIT_W = $clog2(DATA_WIDTH + 4);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_WIDTH);

    rx_state_e             state;
    logic [5:0]            prescale_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic [DATA_WIDTH-1:0] shift;
    logic                  par_bad;
    logic                  stp_bad;
    logic [BIT_W-1:0]      bit_count;
    logic                  consume;

    assign dat_samp_en = (state == START) || (state == DATA) ||
                         (state == PARITY) || (state == STOP);

    uart_rx_edge_bit_counter #(
        .BIT_W(BIT_W)
    ) u_counter (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (dat_samp_en),
        .prescale  (prescale_q),
        .edge_count(edge_count),
        .bit_count (bit_count),
        .wrap      (consume)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            prescale_q <= 6'd0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            shift      <= '0;
            par_bad    <= 1'b0;
            stp_bad    <= 1'b0;
            P_DATA     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!S_DATA) begin
                        state      <= START;
                        prescale_q <= Prescale;
                        par_en_q   <= PAR_EN;
                        par_typ_q  <= PAR_TYP;
                        par_bad    <= 1'b0;
                        stp_bad    <= 1'b0;
                    end
                end
                START: begin
                    // A high start bit at mid-bit means the falling edge was a glitch.
                    if (consume) begin
                        state <= sampled_bit ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (consume) begin
                        shift <= {sampled_bit, shift[DATA_WIDTH-1:1]};
                        if (bit_count == LAST_DATA_BIT) begin
                            state <= par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (consume) begin
                        par_bad <= (sampled_bit != expected_parity(^shift, par_typ_q));
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (consume) begin
                        stp_bad <= !sampled_bit;
                        state   <= DONE;
                        // Load here so P_DATA is already valid during the DONE pulse.
                        if (!par_bad && sampled_bit) begin
                            P_DATA <= shift;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign data_valid = (state == DONE) && !par_bad && !stp_bad;
    assign par_err    = (state == DONE) && par_bad;
    assign stp_err    = (state == DONE) && stp_bad;

`ifdef UART_RX_BREAK_DET_EN
    // A break is a frame whose payload and stop bit are all zero; stp_bad already
    // keeps data_valid low for it.
    assign break_det  = (state == DONE) && stp_bad && (shift == '0);
`else
    assign break_det  = 1'b0;
`endif

endmodule
